// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier with signed/unsigned mode,
// optional early termination and valid/ready handshakes on both sides.
module seq_mult_param #(
    parameter int A_W        = 8,
    parameter int B_W        = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             ab_signed,
    input  logic             ab_valid,
    output logic             ab_ready,
    output logic [A_W+B_W-1:0] z,
    output logic             z_valid,
    input  logic             z_ready
);

    localparam int Z_W = A_W + B_W;
    localparam int S_W = $clog2(B_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    state_t         state, state_d;
    logic [Z_W-1:0] md, md_d;
    logic [Z_W-1:0] acc, acc_d;
    logic [Z_W-1:0] z_d;
    logic [B_W-1:0] mr, mr_d;
    logic [S_W-1:0] step, step_d;
    logic           neg, neg_d;
    logic           ab_ready_d, z_valid_d;
    logic [A_W-1:0] a_mag;
    logic [B_W-1:0] b_mag;
    logic           term;

    // Negating the most-negative value wraps back to 2^(W-1), which is the
    // correct magnitude when read as W-bit unsigned.
    always_comb begin
        a_mag = (ab_signed && a[A_W-1]) ? -a : a;
        b_mag = (ab_signed && b[B_W-1]) ? -b : b;
        term  = (EARLY_TERM != 0) ? (mr == '0) : (step == S_W'(B_W));
    end

    always_comb begin
        state_d    = state;
        md_d       = md;
        mr_d       = mr;
        acc_d      = acc;
        step_d     = step;
        neg_d      = neg;
        z_d        = z;
        ab_ready_d = ab_ready;
        z_valid_d  = z_valid;

        case (state)
            IDLE: begin
                if (ab_valid && ab_ready) begin
                    md_d       = {{B_W{1'b0}}, a_mag};
                    mr_d       = b_mag;
                    neg_d      = ab_signed & (a[A_W-1] ^ b[B_W-1]);
                    acc_d      = '0;
                    step_d     = '0;
                    ab_ready_d = 1'b0;
                    state_d    = MULT;
                end
            end
            MULT: begin
                if (term) begin
                    z_d       = neg ? -acc : acc;
                    z_valid_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    acc_d  = acc + (mr[0] ? md : '0);
                    md_d   = md << 1;
                    mr_d   = mr >> 1;
                    step_d = step + S_W'(1);
                end
            end
            DONE: begin
                if (z_ready) begin
                    z_valid_d  = 1'b0;
                    ab_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            md       <= '0;
            mr       <= '0;
            acc      <= '0;
            step     <= '0;
            neg      <= 1'b0;
            z        <= '0;
            ab_ready <= 1'b1;
            z_valid  <= 1'b0;
        end else begin
            state    <= state_d;
            md       <= md_d;
            mr       <= mr_d;
            acc      <= acc_d;
            step     <= step_d;
            neg      <= neg_d;
            z        <= z_d;
            ab_ready <= ab_ready_d;
            z_valid  <= z_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: directed corner cases on several
// parameterisations plus randomized traffic against an arithmetic model.
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two 8x8 instances: index 0 early-terminating, index 1 fixed latency
    logic [1:0][7:0]  a8, b8;
    logic [1:0]       s8, v8, zr8;
    logic [1:0]       rdy8, zv8;
    logic [1:0][15:0] z8;

    // Small instances sharing handshake stimulus
    logic [4:0]  a2;
    logic [1:0]  b2;
    logic [3:0]  a34;
    logic [7:0]  b34;
    logic        vs, zrs;
    logic        rdy2, zv2, rdy3, zv3, rdy4, zv4;
    logic [6:0]  z2;
    logic [11:0] z3, z4;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] expq[$];

    seq_mult_param #(.A_W(8), .B_W(8), .EARLY_TERM(1)) u0 (
        .clk(clk), .rst(rst_n), .a(a8[0]), .b(b8[0]), .ab_signed(s8[0]),
        .ab_valid(v8[0]), .ab_ready(rdy8[0]), .z(z8[0]), .z_valid(zv8[0]),
        .z_ready(zr8[0]));

    seq_mult_param #(.A_W(8), .B_W(8), .EARLY_TERM(0)) u1 (
        .clk(clk), .rst(rst_n), .a(a8[1]), .b(b8[1]), .ab_signed(s8[1]),
        .ab_valid(v8[1]), .ab_ready(rdy8[1]), .z(z8[1]), .z_valid(zv8[1]),
        .z_ready(zr8[1]));

    seq_mult_param #(.A_W(5), .B_W(2), .EARLY_TERM(1)) u2 (
        .clk(clk), .rst(rst_n), .a(a2), .b(b2), .ab_signed(1'b0),
        .ab_valid(vs), .ab_ready(rdy2), .z(z2), .z_valid(zv2), .z_ready(zrs));

    seq_mult_param #(.A_W(4), .B_W(8), .EARLY_TERM(0)) u3 (
        .clk(clk), .rst(rst_n), .a(a34), .b(b34), .ab_signed(1'b0),
        .ab_valid(vs), .ab_ready(rdy3), .z(z3), .z_valid(zv3), .z_ready(zrs));

    seq_mult_param #(.A_W(4), .B_W(8), .EARLY_TERM(1)) u4 (
        .clk(clk), .rst(rst_n), .a(a34), .b(b34), .ab_signed(1'b0),
        .ab_valid(vs), .ab_ready(rdy4), .z(z4), .z_valid(zv4), .z_ready(zrs));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic s);
        longint px, py, p;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        return p[15:0];
    endfunction

    // Early-terminating latency: bit length of |b| plus one
    function automatic int exp_lat_et1(input logic [7:0] bv, input logic sv);
        int m, k;
        m = (sv && bv[7]) ? 256 - int'(bv) : int'(bv);
        k = 0;
        while (m > 0) begin
            k++;
            m = m / 2;
        end
        return k + 1;
    endfunction

    function automatic logic [7:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'h00;
            2: return 8'hFF;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic issue(input int i, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, output bit ok);
        logic r;
        ok = 1'b0;
        a8[i] = av;
        b8[i] = bv;
        s8[i] = sv;
        v8[i] = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            r = rdy8[i];
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        v8[i] = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_z(input int i, output logic [15:0] zo, output int lat);
        lat = -1;
        zo  = 'x;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (zv8[i]) begin
                lat = c;
                zo  = z8[i];
                break;
            end
        end
    endtask

    task automatic do_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, output logic [15:0] zo, output int lat);
        bit ok;
        issue(i, av, bv, sv, ok);
        zo  = 'x;
        lat = -1;
        if (ok) wait_z(i, zo, lat);
    endtask

    task automatic run_random(input int i, input int n);
        fork
            begin : producer
                logic [7:0] av, bv;
                logic       sv;
                bit         ok;
                for (int k = 0; k < n; k++) begin
                    int g = $urandom_range(0, 2);
                    repeat (g) begin
                        @(posedge clk);
                        #1;
                    end
                    av = rnd_operand();
                    bv = rnd_operand();
                    sv = 1'($urandom_range(0, 1));
                    issue(i, av, bv, sv, ok);
                    if (!ok) break;
                    expq.push_back(ref_mul(av, bv, sv));
                end
            end
            begin : consumer
                int got = 0;
                for (int cyc = 0; cyc < 40 * n && got < n; cyc++) begin
                    zr8[i] = ($urandom_range(0, 3) != 0);
                    if (zv8[i] && zr8[i]) begin
                        if (expq.size() == 0) check("rnd_extra_result", 1, 0);
                        else check("rnd_z", z8[i], expq.pop_front());
                        got++;
                    end
                    @(posedge clk);
                    #1;
                end
                check("rnd_result_count", got, n);
            end
        join
        zr8[i] = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("rnd_idle_zvalid", zv8[i], 0);
        check("rnd_queue_empty", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        logic [15:0] zo;
        int          lat, lat2, lat3, lat4;
        logic [11:0] zc3, zc4;
        logic [6:0]  zc2;
        bit          ok;

        a8 = '0; b8 = '0; s8 = '0; v8 = '0; zr8 = '1;
        a2 = '0; b2 = '0; a34 = '0; b34 = '0; vs = 1'b0; zrs = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ab_ready", rdy8[0], 1);
        check("rst_z_valid", zv8[0], 0);
        check("rst_z", z8[0], 0);
        check("rst_ab_ready_small", {rdy2, rdy3, rdy4}, 3'b111);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Small instances: latency and ready-after-handshake
        a2 = 5'd31; b2 = 2'd3; a34 = 4'd15; b34 = 8'd1; vs = 1'b1;
        lat2 = 0; lat3 = 0; lat4 = 0;
        zc2 = '0; zc3 = '0; zc4 = '0;
        @(posedge clk);
        #1;
        vs = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (zv2 && lat2 == 0) begin lat2 = n; zc2 = z2; end
            if (zv3 && lat3 == 0) begin lat3 = n; zc3 = z3; end
            if (zv4 && lat4 == 0) begin lat4 = n; zc4 = z4; end
            if (lat2 != 0 && n == lat2 + 1) begin
                check("w5x2_ready_after", rdy2, 1);
                check("w5x2_zvalid_drop", zv2, 0);
            end
        end
        check("w5x2_lat", lat2, 3);
        check("w5x2_z", zc2, 93);
        check("w4x8_fixed_lat", lat3, 9);
        check("w4x8_fixed_z", zc3, 15);
        check("w4x8_early_lat", lat4, 2);
        check("w4x8_early_z", zc4, 15);

        // Signed corners on both 8x8 instances
        do_op(0, 8'h80, 8'h80, 1'b1, zo, lat);
        check("s_minmin_z", zo, 16'h4000);
        check("s_minmin_lat", lat, exp_lat_et1(8'h80, 1'b1));
        do_op(0, 8'hFD, 8'h05, 1'b1, zo, lat);
        check("s_neg3x5_z", zo, 16'hFFF1);
        check("s_neg3x5_lat", lat, exp_lat_et1(8'h05, 1'b1));
        do_op(0, 8'h00, 8'h80, 1'b1, zo, lat);
        check("s_zero_neg_z", zo, 0);
        do_op(0, 8'hFF, 8'hFF, 1'b0, zo, lat);
        check("u_ones_z", zo, 16'hFE01);
        check("u_ones_lat", lat, 9);
        do_op(0, 8'h25, 8'h00, 1'b0, zo, lat);
        check("u_b_zero_lat", lat, 1);
        check("u_b_zero_z", zo, 0);
        do_op(1, 8'hFD, 8'h05, 1'b1, zo, lat);
        check("fixed_neg3x5_z", zo, 16'hFFF1);
        check("fixed_neg3x5_lat", lat, 9);

        // Backpressure: result held, new operands ignored while in DONE
        @(posedge clk);
        #1;
        zr8[0] = 1'b0;
        do_op(0, 8'd3, 8'd5, 1'b0, zo, lat);
        check("bp_z", zo, 15);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                a8[0] = 8'd9; b8[0] = 8'd9; v8[0] = 1'b1;
            end else begin
                v8[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_hold_zvalid", zv8[0], 1);
            check("bp_hold_z", z8[0], 15);
            check("bp_hold_ready", rdy8[0], 0);
        end
        v8[0] = 1'b0;
        zr8[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_zvalid", zv8[0], 0);
        check("bp_release_ready", rdy8[0], 1);
        check("bp_release_z_kept", z8[0], 15);
        a8[0] = 8'd2; b8[0] = 8'd9; s8[0] = 1'b0; v8[0] = 1'b1;
        @(posedge clk);
        #1;
        v8[0] = 1'b0;
        check("bp_next_accepted", rdy8[0], 0);
        wait_z(0, zo, lat);
        check("bp_next_z", zo, 18);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an operation
        issue(0, 8'h11, 8'hFF, 1'b0, ok);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ready", rdy8[0], 1);
        check("midrst_zvalid", zv8[0], 0);
        check("midrst_z", z8[0], 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_stale", zv8[0], 0);
        do_op(0, 8'd7, 8'd6, 1'b0, zo, lat);
        check("midrst_after_z", zo, 42);
        check("midrst_after_lat", lat, 4);
        @(posedge clk);
        #1;

        run_random(0, 1000);
        run_random(1, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised shift-add sequential multiplier. Successor to the single-width unsigned multiplier.
- Adds:
  - independent operand widths, with no ordering constraint between them;
  - per-operation signed/unsigned mode;
  - optional early termination;
  - a full valid/ready handshake on both input and output.
- Sits between a producer issuing operand pairs and a consumer that may apply backpressure.
- One operation in flight at a time.

Parameters:
- A_W, 8: multiplicand width, ≥1.
- B_W, 8: multiplier width, ≥1. May be larger or smaller than A_W.
- EARLY_TERM, 1: 1 = stop when the remaining multiplier bits are zero; 0 = always run B_W steps (fixed latency).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous active-low reset.
- a, in, A_W: multiplicand.
- b, in, B_W: multiplier.
- ab_signed, in, 1: 1 = a and b are two's complement; 0 = unsigned. Sampled with a and b.
- ab_valid, in, 1: operand pair valid.
- ab_ready, out, 1: block can accept an operand pair.
- z, out, A_W+B_W: product. Two's complement when the op was signed.
- z_valid, out, 1: z is valid.
- z_ready, in, 1: consumer accepts z.

Behaviour:
- **Interface decisions:** one clock, clk. Reset rst is asynchronous and active-low. All outputs are registered.
- **Reset values:** ab_ready=1, z_valid=0, z=0. State=IDLE and all internal registers cleared.
- **Reset mid-operation:** immediate abort to the reset values. The in-flight result is discarded and no z_valid pulse is produced.

- **States:** IDLE, MULT, DONE.

- **IDLE**
  - ab_ready=1, z_valid=0.
  - Accept on any edge where ab_valid && ab_ready. At that edge:
    - md ← |a| zero-extended to A_W+B_W;
    - mr ← |b| (B_W bits unsigned);
    - neg ← ab_signed & (a[A_W-1] ^ b[B_W-1]);
    - acc ← 0; step ← 0;
    - ab_ready ← 0; state ← MULT.
  - Magnitude when ab_signed=1: negate if MSB set. The most-negative value is handled correctly: |−2^(W−1)| = 2^(W−1) fits in W bits unsigned.
  - When ab_signed=0, the operands are used as-is.
  - ab_valid without ab_ready is ignored. The producer must hold its data until accepted.

- **MULT**
  - ab_ready=0.
  - Termination condition at an edge:
    - EARLY_TERM=1: mr==0;
    - EARLY_TERM=0: step==B_W.
  - If the termination condition is met:
    - z ← neg ? −acc : acc, computed modulo 2^(A_W+B_W);
    - z_valid ← 1; state ← DONE.
  - Otherwise (one step per cycle):
    - acc ← acc + (mr[0] ? md : 0);
    - md ← md<<1; mr ← mr>>1; step ← step+1.
  - The accumulator never overflows, because |a|·|b| < 2^(A_W+B_W).

- **Latency** (edges from the accept edge to the edge that sets z_valid):
  - EARLY_TERM=1: k+1, where k = 1 + bit index of the MSB of |b|, and k=0 when b==0. Range 1..B_W+1.
  - EARLY_TERM=0: always B_W+1.

- **DONE**
  - z_valid=1; z held stable; ab_ready=0.
  - On an edge with z_ready=1: z_valid ← 0, ab_ready ← 1, state ← IDLE. z keeps its last value.
  - While z_ready=0 the block holds indefinitely.
  - No new operand is accepted in DONE. The earliest next accept is the edge after the z handshake edge.

- **Combinational paths:** z_ready has no combinational path to ab_ready. Throughput is one op per (latency + 2) cycles minimum.

- **Corner values:**
  - a=0 or b=0 gives z=0, and neg still applies; −0 = 0.
  - Unsigned all-ones × all-ones gives z = (2^A_W −1)(2^B_W −1).

Test Plan:
1. A_W=5, B_W=2, EARLY_TERM=1, unsigned: a=31, b=3 accepted, z_ready=1 → z_valid exactly 3 edges after the accept edge, z=93; ab_ready=1 on the following cycle.
2. A_W=B_W=8, signed: (a=0x80, b=0x80) → z=0x4000 (16384); (a=0xFD, b=0x05) → z=0xFFF1 (−15); (a=0x00, b=0x80) → z=0.
3. A_W=4, B_W=8, EARLY_TERM=0: b=1, a=15 → latency 9 edges, z=15. With EARLY_TERM=1 the same op → latency 2 edges, z=15.
4. Backpressure: hold z_ready=0 for 10 cycles after z_valid → z and z_valid stable, ab_ready=0, and a new ab_valid pulse is ignored. Raise z_ready → IDLE the next edge; the next op is accepted one cycle later.
5. Assert rst mid-MULT (step 3 of 8) → outputs immediately ab_ready=1, z_valid=0, z=0. Release reset, issue a=7, b=6 unsigned → z=42 and no stale result.
6. Back-to-back random regression: 1000 random ops with mixed ab_signed, random ab_valid/z_ready gaps, for both EARLY_TERM values → every z matches a reference model; exactly one z_valid handshake per accepted op, in order.
